// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: FSM state encodings and
// the layout of a song ROM word.
package music_pkg;

  typedef enum logic [1:0] {
    SEQ_FETCH     = 2'd0,
    SEQ_WAIT_ROM  = 2'd1,
    SEQ_LOAD      = 2'd2,
    SEQ_WAIT_DONE = 2'd3
  } seq_state_t;

  // ROM word is {note[11:6], duration[5:0]}
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  // A zero duration marks the end of a song that is shorter than the ROM page
  localparam logic [5:0] END_MARKER = 6'd0;

endpackage

// File: rtl/song_sequencer_if.sv
// Bus between the song sequencer, its synchronous song ROM and note_player.
interface song_sequencer_if #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
);
  logic [SONG_BITS+NOTE_BITS-1:0] rom_addr;
  logic [11:0]                    rom_data;
  logic                           play;
  logic                           new_note;
  logic [5:0]                     note_to_play;
  logic [5:0]                     duration_for_note;
  logic                           note_done;

  modport master (
    output rom_addr, play, new_note, note_to_play, duration_for_note,
    input  rom_data, note_done
  );

  modport slave (
    input  rom_addr, play, new_note, note_to_play, duration_for_note,
    output rom_data, note_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: steps through the song ROM, hands each note to
// note_player with a one-cycle strobe and waits for it to finish.
// Tracks play/pause, the current song, and end-of-song.
module song_sequencer
  import music_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  song_sequencer_if.master     bus,
  output logic [SONG_BITS-1:0] song,
  output logic                 song_done
);

  seq_state_t           state, state_nx;
  logic                 play, play_nx;
  logic [SONG_BITS-1:0] song_nx;
  logic [NOTE_BITS-1:0] note_idx, idx_nx;
  logic                 song_done_nx;
  logic                 capture;
  logic                 new_note;
  logic [5:0]           note_q, dur_q;
  logic [5:0]           rom_note, rom_dur;

  assign rom_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = bus.rom_data[DUR_MSB:DUR_LSB];

  assign bus.rom_addr          = {song, note_idx};
  assign bus.play              = play;
  assign bus.new_note          = new_note;
  assign bus.note_to_play      = note_q;
  assign bus.duration_for_note = dur_q;

  // Next-state and strobe logic; next_button overrides everything else
  always_comb begin
    state_nx     = state;
    play_nx      = play ^ play_button;
    song_nx      = song;
    idx_nx       = note_idx;
    song_done_nx = 1'b0;
    capture      = 1'b0;
    new_note     = 1'b0;
    case (state)
      SEQ_FETCH: begin
        if (play) state_nx = SEQ_WAIT_ROM;
      end
      SEQ_WAIT_ROM: begin
        capture = 1'b1;
        if (rom_dur == END_MARKER) begin
          state_nx     = SEQ_FETCH;
          song_done_nx = 1'b1;
          play_nx      = 1'b0;
          idx_nx       = '0;
        end else begin
          state_nx = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        new_note = 1'b1;
        state_nx = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        // While paused the note is frozen, so a stray done is not taken
        if (note_done_ok()) begin
          state_nx = SEQ_FETCH;
          if (note_idx == {NOTE_BITS{1'b1}}) begin
            song_done_nx = 1'b1;
            play_nx      = 1'b0;
            idx_nx       = '0;
          end else begin
            idx_nx = note_idx + NOTE_BITS'(1);
          end
        end
      end
      default: state_nx = SEQ_FETCH;
    endcase
    if (next_button) begin
      song_nx      = song + SONG_BITS'(1);
      idx_nx       = '0;
      play_nx      = 1'b0;
      state_nx     = SEQ_FETCH;
      new_note     = 1'b0;
      song_done_nx = 1'b0;
      capture      = 1'b0;
    end
  end

  function automatic logic note_done_ok();
    return bus.note_done && play;
  endfunction

  // State, counters and captured ROM word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEQ_FETCH;
      play      <= 1'b0;
      song      <= '0;
      note_idx  <= '0;
      song_done <= 1'b0;
      note_q    <= '0;
      dur_q     <= '0;
    end else begin
      state     <= state_nx;
      play      <= play_nx;
      song      <= song_nx;
      note_idx  <= idx_nx;
      song_done <= song_done_nx;
      if (capture) begin
        note_q <= rom_note;
        dur_q  <= rom_dur;
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous song ROM.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic play_button;
  logic next_button;
  logic [1:0] song;
  logic song_done;

  int total  = 0;
  int passed = 0;

  logic [11:0] rom [0:127];

  song_sequencer_if #(.SONG_BITS(2), .NOTE_BITS(5)) bus ();

  song_sequencer #(.SONG_BITS(2), .NOTE_BITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .play_button (play_button),
    .next_button (next_button),
    .bus         (bus),
    .song        (song),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nn(input int max, input string tag);
    int n = 0;
    while (bus.new_note !== 1'b1 && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(bus.new_note), 32'd1);
  endtask

  task automatic pulse_play();
    play_button = 1'b1;
    step();
    play_button = 1'b0;
  endtask

  task automatic pulse_done();
    bus.note_done = 1'b1;
    step();
    bus.note_done = 1'b0;
  endtask

  task automatic pulse_next();
    next_button = 1'b1;
    step();
    next_button = 1'b0;
  endtask

  function automatic logic [5:0] exp_note(input int s, input int i);
    if (s == 0 && i == 0) return 6'd20;
    return 6'(s * 8 + i + 1);
  endfunction

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 32; i++)
        rom[s*32+i] = {6'(s * 8 + i + 1), 6'd4};
    rom[0]  = {6'd20, 6'd4};
    rom[35] = {6'd50, 6'd0};

    reset = 1'b0;
    play_button = 1'b0;
    next_button = 1'b0;
    bus.note_done = 1'b0;
    step();
    step();
    check("rst_play",     32'(bus.play), 0);
    check("rst_new_note", 32'(bus.new_note), 0);
    check("rst_song",     32'(song), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_note",     32'(bus.note_to_play), 0);
    check("rst_dur",      32'(bus.duration_for_note), 0);
    reset = 1'b1;
    step();

    // First note: play=1 after one cycle, strobe two cycles later
    pulse_play();
    check("play_c1", 32'(bus.play), 1);
    check("nn_c1", 32'(bus.new_note), 0);
    step();
    check("nn_c2", 32'(bus.new_note), 0);
    step();
    check("nn_c3", 32'(bus.new_note), 1);
    check("note0", 32'(bus.note_to_play), 20);
    check("dur0",  32'(bus.duration_for_note), 4);
    check("addr0", 32'(bus.rom_addr), 0);

    // Walk the rest of song 0, three cycles from done to next strobe
    for (int i = 1; i < 32; i++) begin
      step();
      check("nn_pulse_width", 32'(bus.new_note), 0);
      pulse_done();
      check("addr_inc", 32'(bus.rom_addr), 32'(i));
      step();
      step();
      check("nn_lat3", 32'(bus.new_note), 1);
      check("note_s0", 32'(bus.note_to_play), 32'(exp_note(0, i)));
    end
    step();
    pulse_done();
    check("end_song_done", 32'(song_done), 1);
    check("end_play",      32'(bus.play), 0);
    check("end_addr",      32'(bus.rom_addr), 0);
    check("end_song",      32'(song), 0);
    step();
    check("song_done_1cyc", 32'(song_done), 0);

    // Song 1 ends early on the zero-duration word at index 3
    pulse_next();
    check("next_song1", 32'(song), 1);
    pulse_play();
    for (int i = 0; i < 3; i++) begin
      wait_nn(4, "s1_nn");
      check("note_s1", 32'(bus.note_to_play), 32'(exp_note(1, i)));
      step();
      pulse_done();
    end
    check("s1_addr3", 32'(bus.rom_addr), 35);
    step();
    step();
    check("marker_song_done", 32'(song_done), 1);
    check("marker_play",      32'(bus.play), 0);
    check("marker_nn",        32'(bus.new_note), 0);
    check("marker_addr",      32'(bus.rom_addr), 32);
    for (int k = 0; k < 3; k++) begin
      step();
      check("marker_no_nn", 32'(bus.new_note), 0);
    end

    // Wrap from song 3 to song 0 while waiting on a note
    pulse_next();
    pulse_next();
    check("song3", 32'(song), 3);
    pulse_play();
    wait_nn(4, "s3_nn");
    check("note_s3", 32'(bus.note_to_play), 32'(exp_note(3, 0)));
    step();
    pulse_next();
    check("wrap_song", 32'(song), 0);
    check("wrap_play", 32'(bus.play), 0);
    check("wrap_addr", 32'(bus.rom_addr), 0);
    check("wrap_nn",   32'(bus.new_note), 0);
    check("wrap_sd",   32'(song_done), 0);
    pulse_play();
    wait_nn(2, "wrap_replay_nn");
    check("wrap_replay_note", 32'(bus.note_to_play), 20);

    // next and play together while playing: next wins
    step();
    play_button = 1'b1;
    next_button = 1'b1;
    step();
    play_button = 1'b0;
    next_button = 1'b0;
    check("both_song", 32'(song), 1);
    check("both_play", 32'(bus.play), 0);
    pulse_done();
    pulse_done();
    check("done_in_fetch", 32'(bus.rom_addr), 32);

    // Pause while a note is held; done is ignored until resumed
    pulse_play();
    wait_nn(3, "pause_nn");
    step();
    pulse_play();
    check("paused", 32'(bus.play), 0);
    pulse_done();
    check("paused_done_ign", 32'(bus.rom_addr), 32);
    pulse_play();
    check("resumed", 32'(bus.play), 1);
    pulse_done();
    check("resumed_done", 32'(bus.rom_addr), 33);
    step();

    // Asynchronous reset in the middle of the ROM wait
    #3;
    reset = 1'b0;
    #1;
    check("arst_play",     32'(bus.play), 0);
    check("arst_song",     32'(song), 0);
    check("arst_addr",     32'(bus.rom_addr), 0);
    check("arst_note",     32'(bus.note_to_play), 0);
    check("arst_dur",      32'(bus.duration_for_note), 0);
    check("arst_nn",       32'(bus.new_note), 0);
    check("arst_sd",       32'(song_done), 0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_rst_no_nn", 32'(bus.new_note), 0);
    end
    check("post_rst_play", 32'(bus.play), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Control sequencer that feeds the note_player from a synchronous song ROM.
- Holds play/pause state and the current song.
- Fetches note/duration words, issues one-cycle load_new_note pulses, and waits for done_with_note before the next fetch.
- Detects end of song and handles next-song requests.
- Sits between the debounced, one-pulsed buttons and note_player; its play output drives note_player play_enable.

Parameters:
- SONG_BITS, 2, song select width; NUM_SONGS = 2**SONG_BITS.
- NOTE_BITS, 5, note index width; NOTES_PER_SONG = 2**NOTE_BITS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- play_button  in  1  one-cycle pulse, toggles play
- next_button  in  1  one-cycle pulse, advance song
- note_done  in  1  one-cycle pulse from note_player done_with_note
- rom_data  in  12  {note[11:6], duration[5:0]}, valid one cycle after rom_addr
- rom_addr  out  SONG_BITS+NOTE_BITS  {song, note_idx}, combinational from registers
- play  out  1  play enable to note_player
- new_note  out  1  one-cycle load strobe
- note_to_play  out  6  registered note
- duration_for_note  out  6  registered duration in beats
- song  out  SONG_BITS  current song
- song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (async assert, sync release): play=0, song=0, note_idx=0, state=FETCH, new_note=0, song_done=0, note_to_play=0, duration_for_note=0.
- States: FETCH, WAIT_ROM, LOAD, WAIT_DONE.
- FETCH: rom_addr presents {song, note_idx}. If play=1, go to WAIT_ROM; otherwise hold.
- WAIT_ROM: capture rom_data into note_to_play/duration_for_note at the end of the cycle.
  - If captured duration==0 (end marker), go to FETCH with song_done=1 next cycle, play<=0, note_idx<=0.
  - Otherwise go to LOAD.
- LOAD: new_note=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: on note_done:
  - If note_idx==NOTES_PER_SONG-1: song_done pulse, play<=0, note_idx<=0, go to FETCH.
  - Else note_idx<=note_idx+1, go to FETCH.
- Latency: with play=1 in FETCH, new_note rises 2 cycles later. note_done to next new_note is 3 cycles.
- play_button toggles play in any state.
  - Pausing in WAIT_DONE keeps the state; note_player holds the note.
  - Pausing in WAIT_ROM or LOAD still completes the load, then waits in WAIT_DONE.
- next_button, any state: song<=song+1 (wraps NUM_SONGS-1 to 0), note_idx<=0, play<=0, state<=FETCH, new_note forced 0 that cycle. No song_done.
- Simultaneous next_button and play_button: next wins, play=0.
- Simultaneous next_button and note_done: next wins, note_done dropped.
- note_done outside WAIT_DONE is ignored.
- song_done is never asserted in the same cycle as new_note.
- Reset mid-song aborts immediately. Outputs return to reset values regardless of clk.

Decomposition:
- Shared package music_pkg holds:
  - state encodings SEQ_FETCH, SEQ_WAIT_ROM, SEQ_LOAD, SEQ_WAIT_DONE
  - ROM field constants NOTE_MSB=11, NOTE_LSB=6, DUR_MSB=5, DUR_LSB=0
  - END_MARKER=6'd0
- No sub-module: one FSM plus song/note_idx counters. The song ROM is instantiated alongside it in music_player, not inside.

Test Plan:
- Reset, then play_button pulse at cycle 0 with ROM {song0,idx0}=note 6'd20/dur 6'd4 → play=1 at cycle 1; new_note=1 for one cycle at cycle 3 with note_to_play=20, duration_for_note=4; rom_addr=0.
- note_done pulse in WAIT_DONE → new_note 3 cycles later; rom_addr=1; note_idx increments 0→1→…→31. The note_done after index 31 gives song_done=1, play=0, rom_addr=0, song unchanged.
- ROM word at {song1,idx3} has dur=0 → after idx2 completes: song_done pulse, play=0, no new_note issued for idx3.
- next_button while song=3 in WAIT_DONE → song=0, play=0, state FETCH, rom_addr=0. A following play_button loads song0 idx0 within 3 cycles.
- Same-cycle play_button+next_button while playing → song increments, play=0. note_done pulses while in FETCH/paused do not change note_idx.
- Drive reset low asynchronously mid-WAIT_ROM (between clk edges) → all outputs zero immediately. After release, no new_note until play_button.
